mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Channel-scan controller that sits directly upstream of the 4:1 single-bit multiplexer, `mux_4`. It drives the mux `sel` input and reads back the mux `out`. On a start request it steps `sel` through a registered mask of enabled channels in ascending order and holds each channel for a programmable dwell time. It samples the mux output on the last dwell cycle of each channel and, after the highest enabled channel, presents the assembled 4-bit frame with a one-cycle valid pulse.

## Interface
Parameters:
- `DWELL_W`, default 4: width of the dwell count; per-channel hold is `dwell`+1 cycles.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  input  1  rising-edge system clock
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  scan request, sampled on a rising edge of `clk`
- `enable_mask`  input  4  bit i enables channel i (0=a, 1=b, 2=c, 3=d); captured when a start is accepted
- `dwell`  input  `DWELL_W`  hold count; captured when a start is accepted
- `mux_in`  input  1  connected to the mux `out`
- `sel`  output  2  connected to the mux `sel`; registered
- `busy`  output  1  high while a scan is in progress
- `frame`  output  4  bit i holds the last sample of channel i; disabled channels read 0
- `frame_valid`  output  1  one-cycle pulse when `frame` updates

## Operation
States: IDLE, SCAN.

IDLE:
- `busy`=0 and `sel`=2'b00.
- On `start`=1 with `enable_mask`≠0: capture the mask and `dwell`, set `sel` to the lowest enabled channel, clear the dwell counter and the sample buffer, set `busy`=1, and go to SCAN.
- `start` with `enable_mask`=0 is ignored. The block stays in IDLE and no `frame_valid` is produced.

SCAN:
- The dwell counter increments each cycle.
- On the edge where counter == captured `dwell`:
  - Write `mux_in` into sample buffer bit `sel`.
  - If a higher enabled channel exists: `sel` moves to the next higher enabled channel and the counter clears.
  - If not (last channel): `frame` is loaded from the buffer, including this sample, with disabled bits forced to 0. `frame_valid` is set to 1, `busy` to 0, `sel` to 2'b00, and the state returns to IDLE.
- `start` during SCAN is ignored; there is no queuing.
- Changes to `enable_mask` or `dwell` during SCAN have no effect, because both were captured at start.
- `frame` holds its value until the next completed scan. An aborted scan never updates it.

Arithmetic:
- The counter is `DWELL_W` bits wide and compares against the captured `dwell` only, so it never wraps.
- `dwell`=0 gives 1 cycle per channel.
- `dwell`=2^`DWELL_W`−1 gives 2^`DWELL_W` cycles per channel.

## Timing
- Reset values: `sel`=0, `busy`=0, `frame`=0, `frame_valid`=0, state IDLE, counter 0, buffer 0.
- Start accepted at edge E0: `sel`, `busy` and `frame` are all registered, so `sel` shows the first channel in the cycle after E0.
- Channel k (k = 0..N−1, N = enabled count) is sampled at edge E(k+1)(`dwell`+1).
- `frame` and `frame_valid` update at edge E(N(`dwell`+1)). The pulse lasts exactly one cycle.
- `busy` is high from after E0 through the last sample edge, where it drops together with the rise of `frame_valid`.
- A new `start` is accepted at the earliest on the edge after the one where `busy` falls, i.e. while `frame_valid` is high.
- `mux_in` is combinational from `sel` through the mux. It is sampled `dwell`+1 edges after `sel` changes, so the settling margin is `dwell` extra cycles.
- `rst` asserted mid-scan: all outputs return to their reset values immediately, without waiting for a clock edge. The partial buffer is discarded.

## Configuration
- `MUX_SCAN_CONTINUOUS_EN` defined:
  - On the last-channel edge the block still pulses `frame_valid`.
  - If `start` is held high on that edge, it re-enters SCAN directly instead of going to IDLE. It recaptures `enable_mask` and `dwell`, sets `sel` to the new lowest enabled channel, and keeps `busy`=1.
  - If the new mask is 0, it goes to IDLE.
- Not defined: always return to IDLE after a frame. The minimum gap between frames is one IDLE cycle.

## Test plan
- Reset, then start with mask 4'b1111, `dwell`=0, a=1 b=0 c=1 d=1:
  - `sel` steps 0,1,2,3, one cycle each.
  - `frame_valid` pulses 4 cycles after the start edge.
  - `frame`=4'b1101, `busy` high for 4 cycles.
- Start with mask 4'b0101, `dwell`=2, a=1 c=1:
  - `sel`=0 for 3 cycles, then 2 for 3 cycles.
  - Valid pulses 6 cycles after start; `frame`=4'b0101.
  - Channels 1 and 3 are never selected.
- Start with mask 4'b0000 → `busy` stays 0, no `frame_valid`, `frame` unchanged.
- Mid-scan: pulse `start` again and change the mask → ignored, timing as the first case, `frame` reflects the original mask.
- Assert `rst` during channel 2 of a 4'b1111 scan → `sel`=0, `busy`=0, `frame`=0 and `frame_valid`=0 before the next edge; no pulse after release.
- With `MUX_SCAN_CONTINUOUS_EN` defined, `start` held high, mask 4'b1000, `dwell`=1:
  - `frame_valid` pulses every 2 cycles and `busy` never drops.
  - Without the macro, pulses occur every 3 cycles.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - channel-scan controller driving a 4:1 mux select and assembling sampled frames
// Optional feature macro: MUX_SCAN_CONTINUOUS_EN (back-to-back scans while start is held)

module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         enable_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_in,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [3:0]         frame,
  output logic               frame_valid
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [3:0]         r_mask;
  logic [3:0]         w_mask_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [3:0]         r_buf;
  logic [3:0]         w_buf_nxt;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [3:0]         r_frame;
  logic [3:0]         w_frame_nxt;
  logic               r_frame_valid;
  logic               w_frame_valid_nxt;

  logic               w_start_ok;
  logic               w_capture;
  logic               w_last_dwell;
  logic [3:0]         w_above_mask;
  logic               w_has_next;
  logic [1:0]         w_next_sel;
  logic [1:0]         w_first_sel;
  logic [3:0]         w_buf_upd;

  // Index of the lowest set bit; 0 when the mask is empty (callers guard that case)
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] v;
    v = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) v = i[1:0];
    end
    return v;
  endfunction

  assign w_start_ok   = start && (enable_mask != 4'b0000);
  assign w_first_sel  = f_lowest(enable_mask);
  assign w_last_dwell = (r_cnt == r_dwell);
  // Enabled channels strictly above the one currently selected
  assign w_above_mask = r_mask & (4'b1110 << r_sel);
  assign w_has_next   = |w_above_mask;
  assign w_next_sel   = f_lowest(w_above_mask);

  // Sample buffer with the current mux value merged in at the selected channel
  always_comb begin
    w_buf_upd        = r_buf;
    w_buf_upd[r_sel] = mux_in;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; a capture reloads mask/dwell and restarts the sweep
  always_comb begin
    w_state_nxt       = r_state;
    w_mask_nxt        = r_mask;
    w_dwell_nxt       = r_dwell;
    w_cnt_nxt         = r_cnt;
    w_buf_nxt         = r_buf;
    w_sel_nxt         = r_sel;
    w_busy_nxt        = r_busy;
    w_frame_nxt       = r_frame;
    w_frame_valid_nxt = 1'b0;
    w_capture         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        w_sel_nxt  = 2'b00;
        if (w_start_ok) begin
          w_capture = 1'b1;
        end
      end

      ST_SCAN: begin
        if (w_last_dwell) begin
          w_buf_nxt = w_buf_upd;
          if (w_has_next) begin
            w_sel_nxt = w_next_sel;
            w_cnt_nxt = '0;
          end else begin
            w_frame_nxt       = w_buf_upd & r_mask;
            w_frame_valid_nxt = 1'b1;
            w_busy_nxt        = 1'b0;
            w_sel_nxt         = 2'b00;
            w_cnt_nxt         = '0;
            w_state_nxt       = ST_IDLE;
`ifdef MUX_SCAN_CONTINUOUS_EN
            if (w_start_ok) begin
              w_capture = 1'b1;
            end
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_sel_nxt   = 2'b00;
      end
    endcase

    if (w_capture) begin
      w_state_nxt = ST_SCAN;
      w_mask_nxt  = enable_mask;
      w_dwell_nxt = dwell;
      w_sel_nxt   = w_first_sel;
      w_cnt_nxt   = '0;
      w_buf_nxt   = 4'b0000;
      w_busy_nxt  = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask        <= 4'b0000;
      r_dwell       <= '0;
      r_cnt         <= '0;
      r_buf         <= 4'b0000;
      r_sel         <= 2'b00;
      r_busy        <= 1'b0;
      r_frame       <= 4'b0000;
      r_frame_valid <= 1'b0;
    end else begin
      r_mask        <= w_mask_nxt;
      r_dwell       <= w_dwell_nxt;
      r_cnt         <= w_cnt_nxt;
      r_buf         <= w_buf_nxt;
      r_sel         <= w_sel_nxt;
      r_busy        <= w_busy_nxt;
      r_frame       <= w_frame_nxt;
      r_frame_valid <= w_frame_valid_nxt;
    end
  end

  assign sel         = r_sel;
  assign busy        = r_busy;
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with a schedule-based reference model

module tb_mux_scan_ctrl;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    enable_mask;
  logic [DW-1:0] dwell;
  logic          mux_in;
  logic [1:0]    sel;
  logic          busy;
  logic [3:0]    frame;
  logic          frame_valid;

  logic [3:0]    ch;
  logic          chk_en = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  // The 4:1 mux the controller drives
  assign mux_in = ch[sel];

  mux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .enable_mask (enable_mask),
    .dwell       (dwell),
    .mux_in      (mux_in),
    .sel         (sel),
    .busy        (busy),
    .frame       (frame),
    .frame_valid (frame_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a scan is a list of enabled channels, each held dwell+1 cycles;
  // the frame is the channel values masked by the enable set, delivered N*(dwell+1) cycles after start.
  logic       m_active = 1'b0;
  int         m_t = 0;
  int         m_n = 0;
  int         m_d = 0;
  logic [3:0] m_mask = 4'b0000;
  int         m_list[4];
  logic [1:0] e_sel = 2'b00;
  logic       e_busy = 1'b0;
  logic [3:0] e_frame = 4'b0000;
  logic       e_fv = 1'b0;

  task m_begin();
    m_active = 1'b1;
    m_t      = 0;
    m_mask   = enable_mask;
    m_d      = int'(dwell);
    m_n      = 0;
    for (int i = 0; i < 4; i++) begin
      if (enable_mask[i]) begin
        m_list[m_n] = i;
        m_n++;
      end
    end
    e_sel = 2'(m_list[0]);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      e_sel    = 2'b00;
      e_busy   = 1'b0;
      e_frame  = 4'b0000;
      e_fv     = 1'b0;
    end else begin
      e_fv = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == m_n * (m_d + 1)) begin
          e_frame  = ch & m_mask;
          e_fv     = 1'b1;
          m_active = 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
          if (start && enable_mask != 4'b0000) m_begin();
`endif
        end else begin
          e_sel = 2'(m_list[m_t / (m_d + 1)]);
        end
      end else if (start && enable_mask != 4'b0000) begin
        m_begin();
      end
      if (!m_active) e_sel = 2'b00;
      e_busy = m_active;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("sel", 32'(sel), 32'(e_sel));
      check("busy", 32'(busy), 32'(e_busy));
      check("frame", 32'(frame), 32'(e_frame));
      check("frame_valid", 32'(frame_valid), 32'(e_fv));
    end
  end

  task automatic do_scan(input string tag, input logic [3:0] m, input logic [DW-1:0] d,
                         input logic [3:0] chv, input logic [3:0] exp_f, input int exp_lat,
                         input logic [3:0] exp_seen, input bit poke);
    int         lat;
    int         busy_cnt;
    logic [3:0] seen;
    bit         got;
    ch = chv;
    @(negedge clk);
    start       = 1'b1;
    enable_mask = m;
    dwell       = d;
    lat      = 0;
    busy_cnt = 0;
    seen     = 4'b0000;
    got      = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) start = 1'b0;
      if (poke && lat == 2) begin
        start       = 1'b1;
        enable_mask = 4'b0001;
        dwell       = 7;
      end
      if (poke && lat == 3) start = 1'b0;
      if (busy) begin
        busy_cnt++;
        seen[sel] = 1'b1;
      end
      if (frame_valid) got = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat - 1), 32'(exp_lat));
    check({tag, "_frame"}, 32'(frame), 32'(exp_f));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_channels_selected"}, 32'(seen), 32'(exp_seen));
    @(negedge clk);
  endtask

  initial begin
    int   lat;
    int   pulses;
    int   p[3];
    int   low_cnt;
    bit   found;

    rst         = 1'b1;
    start       = 1'b0;
    enable_mask = 4'b0000;
    dwell       = '0;
    ch          = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame", 32'(frame), 32'd0);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // a=1 b=0 c=1 d=1, all channels, one cycle each
    do_scan("all_d0", 4'b1111, 4'd0, 4'b1101, 4'b1101, 4, 4'b1111, 1'b0);
    // Channels a and c only, dwell 2; b and d held high must still read 0
    do_scan("ac_d2", 4'b0101, 4'd2, 4'b1111, 4'b0101, 6, 4'b0101, 1'b0);

    // Empty mask is ignored
    @(negedge clk);
    start       = 1'b1;
    enable_mask = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    check("empty_mask_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("empty_mask_frame_kept", 32'(frame), 32'h5);
    check("empty_mask_no_valid", 32'(frame_valid), 32'd0);

    // Restart and mask/dwell change mid-scan are ignored
    do_scan("mid_poke", 4'b1111, 4'd0, 4'b0110, 4'b0110, 4, 4'b1111, 1'b1);
    // Maximum dwell: 16 cycles on a single channel
    do_scan("max_dwell", 4'b0010, 4'd15, 4'b0010, 4'b0010, 16, 4'b0010, 1'b0);

    // Asynchronous reset during channel 2
    ch = 4'b1011;
    @(negedge clk);
    start       = 1'b1;
    enable_mask = 4'b1111;
    dwell       = 4'd3;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (sel == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_reached_ch2", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_sel", 32'(sel), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_frame", 32'(frame), 32'd0);
    check("rst_async_frame_valid", 32'(frame_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_valid) pulses++;
    end
    check("rst_no_pulse_after", 32'(pulses), 32'd0);

    // Start held high on a single channel with dwell 1
    ch = 4'b1000;
    @(negedge clk);
    start       = 1'b1;
    enable_mask = 4'b1000;
    dwell       = 4'd1;
    pulses  = 0;
    low_cnt = 0;
    lat     = 0;
    while (pulses < 3 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (pulses >= 1 && !busy) low_cnt++;
      if (frame_valid) begin
        p[pulses] = lat;
        pulses++;
      end
    end
    start = 1'b0;
    check("hold_pulse_count", 32'(pulses), 32'd3);
`ifdef MUX_SCAN_CONTINUOUS_EN
    check("hold_gap_1", 32'(p[1] - p[0]), 32'd2);
    check("hold_gap_2", 32'(p[2] - p[1]), 32'd2);
    check("hold_busy_low_cycles", 32'(low_cnt), 32'd0);
`else
    check("hold_gap_1", 32'(p[1] - p[0]), 32'd3);
    check("hold_gap_2", 32'(p[2] - p[1]), 32'd3);
    check("hold_busy_low_cycles", 32'(low_cnt), 32'd2);
`endif
    check("hold_frame", 32'(frame), 32'h8);
    repeat (6) @(negedge clk);
    check("hold_idle_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
